// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared encodings, FSM states and buffer entry type for the store issue path
package store_pkg;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

endpackage

// File: rtl/store_issue_ctrl_if.sv
// rtl/store_issue_ctrl_if.sv - store request, memory write port and status signals of the store issue controller
interface store_issue_ctrl_if;

  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_sel;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign_err;
  logic        timeout_err;
  logic        busy;

  modport master (
    output st_valid, st_sel, st_addr, st_data, flush, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           misalign_err, timeout_err, busy
  );

  modport slave (
    input  st_valid, st_sel, st_addr, st_data, flush, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           misalign_err, timeout_err, busy
  );

endinterface

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - synchronous store buffer; can flush everything or everything but the head in flight
module store_fifo
  import store_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush_keep_head,
  input  logic          flush_all,
  input  entry_t        din,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_all) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else if (flush_keep_head) begin
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr <= rd_ptr + PW'(1);
      count  <= pop ? '0 : CW'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/store_issue_ctrl.sv
// rtl/store_issue_ctrl.sv - aligns, lane-formats and buffers RV32I stores, then issues them to data memory with a watchdog
module store_issue_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  store_issue_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  state_t        state_nxt;
  entry_t        fmt;
  entry_t        head;
  logic          bad;
  logic          accept;
  logic          push;
  logic          pop;
  logic          handshake;
  logic          timeout_hit;
  logic          full;
  logic          empty;
  logic          ready_en;
  logic          mem_valid_c;
  logic          misalign_q;
  logic          timeout_q;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  // ready_en keeps st_ready low through reset and rises on the first edge after release.
  assign bus.st_ready = ready_en && !full && !bus.flush;
  assign accept       = bus.st_valid && bus.st_ready;
  assign push         = accept && !bad;
  assign handshake    = (state == ISSUE) && bus.mem_ready;
  assign timeout_hit  = (state == ISSUE) && !bus.mem_ready && (timer == TW'(TIMEOUT - 1));
  assign pop          = handshake || timeout_hit;

  always_comb begin
    fmt       = '0;
    bad       = 1'b0;
    fmt.addr  = {bus.st_addr[31:2], 2'b00};
    case (bus.st_sel)
      ST_SB: begin
        fmt.wdata = {4{bus.st_data[7:0]}};
        fmt.wstrb = 4'b0001 << bus.st_addr[1:0];
      end
      ST_SH: begin
        fmt.wdata = {2{bus.st_data[15:0]}};
        fmt.wstrb = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        bad       = bus.st_addr[0];
      end
      ST_SW: begin
        fmt.wdata = bus.st_data;
        fmt.wstrb = 4'b1111;
        bad       = (bus.st_addr[1:0] != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .pop             (pop),
    .flush_keep_head (bus.flush && (state == ISSUE)),
    .flush_all       (bus.flush && (state == IDLE)),
    .din             (fmt),
    .head            (head),
    .full            (full),
    .empty           (empty),
    .count           (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // After a handshake, stay in ISSUE only if an entry survives (no bubble between back-to-back writes).
  always_comb begin
    state_nxt   = state;
    mem_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.flush) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_valid_c = 1'b1;
        if (timeout_hit)
          state_nxt = IDLE;
        else if (handshake && !(((count > CW'(1)) && !bus.flush) || push))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      ready_en   <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      misalign_q <= accept && bad;
      timeout_q  <= timeout_hit;
      if ((state == ISSUE) && !pop) timer <= timer + TW'(1);
      else                          timer <= '0;
    end
  end

  assign bus.mem_valid    = mem_valid_c;
  assign bus.mem_addr     = mem_valid_c ? head.addr  : '0;
  assign bus.mem_wdata    = mem_valid_c ? head.wdata : '0;
  assign bus.mem_wstrb    = mem_valid_c ? head.wstrb : '0;
  assign bus.misalign_err = misalign_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.busy         = (count != '0) || (state == ISSUE);

endmodule

// File: tb/tb_store_issue_ctrl.sv
// tb/tb_store_issue_ctrl.sv - randomized scoreboard bench plus directed cases for store_issue_ctrl
module tb_store_issue_ctrl;
  import store_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_issue_ctrl_if bus();

  store_issue_ctrl #(.DEPTH(2), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wr_t exp_q[$];
  int  mis_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  rand_mode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a store of `size` bytes at byte offset `off` touches lanes off..off+size-1,
  // and lane i carries data byte (i mod size).
  function automatic bit predict(input logic [1:0] sel, input logic [31:0] a,
                                 input logic [31:0] d, output wr_t w);
    int unsigned size;
    int unsigned off;
    size = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    off  = a % 4;
    w.addr  = a - off;
    w.wdata = '0;
    w.wstrb = '0;
    if (sel == 2'd3 || (a % size) != 0) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      w.wdata[8*i +: 8] = d[8*(i % size) +: 8];
      if (i >= off && i < off + size) w.wstrb[i] = 1'b1;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rand_mode) begin
      bit mis_exp;
      mis_exp = (mis_q.size() > 0) && (mis_q[0] == cyc);
      chk("misalign_err", bus.misalign_err, mis_exp);
      if (mis_exp) void'(mis_q.pop_front());
      chk("timeout_err_idle", bus.timeout_err, 0);
      if (bus.mem_valid) begin
        chk("mem_valid_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("mem_addr", bus.mem_addr, exp_q[0].addr);
          chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
          chk("mem_wstrb", bus.mem_wstrb, exp_q[0].wstrb);
          if (bus.mem_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_store(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_sel   = sel;
    bus.st_addr  = a;
    bus.st_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.st_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    chk("store_accepted", acc, 1);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    bit third_acc;
    int vcount;
    int low_streak;
    int seen;
    logic [31:0] a;
    logic [1:0]  sel;
    wr_t         w;
    logic [31:0] t3_addr [3];

    bus.st_valid = 0; bus.st_sel = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.flush = 0; bus.mem_ready = 0;

    #12;
    chk("rst_st_ready", bus.st_ready, 0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("st_ready_before_first_edge", bus.st_ready, 0);
    @(negedge clk);
    chk("st_ready_after_reset", bus.st_ready, 1);

    // Randomized phase: memory stalls are kept short so the watchdog never fires.
    rand_mode  = 1'b1;
    low_streak = 0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 9))
        0, 1, 2: sel = 2'd0;
        3, 4, 5: sel = 2'd1;
        6, 7, 8: sel = 2'd2;
        default: sel = 2'd3;
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sel == 2'd1) a[0] = 1'b0;
        else if (sel == 2'd2) a[1:0] = 2'b00;
      end
      bus.st_valid = ($urandom_range(0, 99) < 60);
      bus.st_sel   = sel;
      bus.st_addr  = a;
      bus.st_data  = $urandom;
      bus.mem_ready = (low_streak >= 6) ? 1'b1 : ($urandom_range(0, 99) < 65);
      low_streak = bus.mem_ready ? 0 : low_streak + 1;
      @(negedge clk);
      if (bus.st_valid && bus.st_ready) begin
        if (predict(bus.st_sel, bus.st_addr, bus.st_data, w)) exp_q.push_back(w);
        else mis_q.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    bus.st_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_expected_empty", exp_q.size(), 0);
    chk("drain_misalign_empty", mis_q.size(), 0);
    chk("drain_busy", bus.busy, 0);
    rand_mode = 1'b0;
    @(posedge clk);
    #1;

    // Byte store into the top lane.
    do_store(ST_SB, 32'h0000_1003, 32'hAABB_CCDD);
    wait_valid(5, ok);
    chk("t1_valid", ok, 1);
    chk("t1_addr", bus.mem_addr, 32'h0000_1000);
    chk("t1_wdata", bus.mem_wdata, 32'hDDDD_DDDD);
    chk("t1_wstrb", bus.mem_wstrb, 4'b1000);
    @(negedge clk);
    chk("t1_busy_fall", bus.busy, 0);

    // Aligned upper half, then a misaligned half.
    @(posedge clk);
    #1;
    do_store(ST_SH, 32'h0000_2002, 32'h1234_5678);
    wait_valid(5, ok);
    chk("t2_valid", ok, 1);
    chk("t2_wdata", bus.mem_wdata, 32'h5678_5678);
    chk("t2_wstrb", bus.mem_wstrb, 4'b1100);
    @(posedge clk);
    #1;
    do_store(ST_SH, 32'h0000_2001, 32'h1234_5678);
    @(negedge clk);
    chk("t2_misalign_pulse", bus.misalign_err, 1);
    chk("t2_misalign_no_valid", bus.mem_valid, 0);
    chk("t2_misalign_busy", bus.busy, 0);
    @(negedge clk);
    chk("t2_misalign_pulse_end", bus.misalign_err, 0);
    chk("t2_misalign_no_valid2", bus.mem_valid, 0);

    // Fill the two-entry buffer, then drain in order with no bubble.
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    t3_addr[0] = 32'h100; t3_addr[1] = 32'h104; t3_addr[2] = 32'h108;
    do_store(ST_SW, t3_addr[0], 32'h1111_1111);
    do_store(ST_SW, t3_addr[1], 32'h2222_2222);
    bus.st_valid = 1'b1; bus.st_sel = ST_SW; bus.st_addr = t3_addr[2]; bus.st_data = 32'h3333_3333;
    @(negedge clk);
    chk("t3_full_st_ready", bus.st_ready, 0);
    chk("t3_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    third_acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_no_bubble", bus.mem_valid, 1);
      chk("t3_order_addr", bus.mem_addr, t3_addr[k]);
      if (bus.st_valid && bus.st_ready) third_acc = 1'b1;
      @(posedge clk);
      #1;
      if (third_acc) bus.st_valid = 1'b0;
    end
    chk("t3_third_accepted", third_acc, 1);
    @(negedge clk);
    chk("t3_idle_after", bus.mem_valid, 0);
    chk("t3_busy_after", bus.busy, 0);

    // Watchdog: mem_valid held exactly TIMEOUT cycles, then dropped.
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    do_store(ST_SW, 32'h200, 32'h4444_4444);
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_valid) vcount++;
      else if (vcount > 0) begin
        chk("t4_timeout_pulse", bus.timeout_err, 1);
        chk("t4_busy", bus.busy, 0);
        break;
      end
    end
    chk("t4_valid_cycles", vcount, 16);
    @(negedge clk);
    chk("t4_timeout_pulse_end", bus.timeout_err, 0);

    // Flush: empty buffer refuses the store; in ISSUE only the head in flight survives.
    @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.st_valid = 1'b1; bus.st_sel = ST_SW; bus.st_addr = 32'h2F0;
    @(negedge clk);
    chk("t5_flush_st_ready_empty", bus.st_ready, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.st_valid = 1'b0;
    @(negedge clk);
    chk("t5_flush_nothing_taken", bus.busy, 0);
    @(posedge clk);
    #1;
    do_store(ST_SW, 32'h300, 32'h5555_5555);
    do_store(ST_SW, 32'h304, 32'h6666_6666);
    bus.flush = 1'b1; bus.st_valid = 1'b1; bus.st_addr = 32'h308;
    @(negedge clk);
    chk("t5_flush_st_ready", bus.st_ready, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.st_valid = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_head_kept", bus.mem_valid, 1);
    chk("t5_head_addr", bus.mem_addr, 32'h300);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_valid) seen++;
    end
    chk("t5_second_discarded", seen, 0);
    chk("t5_busy_after", bus.busy, 0);

    // Asynchronous reset in the middle of a write.
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    do_store(ST_SW, 32'h400, 32'hCAFE_F00D);
    wait_valid(5, ok);
    chk("t6_in_issue", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_valid", bus.mem_valid, 0);
    chk("t6_rst_st_ready", bus.st_ready, 0);
    chk("t6_rst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_st_ready_after", bus.st_ready, 1);
    chk("t6_busy_after", bus.busy, 0);
    chk("t6_mem_valid_after", bus.mem_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/store_issue_ctrl.md
Name: store_issue_ctrl

Overview:
Sequences RV32I store instructions from the execute stage onto the data-memory write port.
- Accepts one store per handshake and checks alignment.
- Formats byte/half/word data into the correct byte lanes with write strobes.
- Buffers stores in a small FIFO and issues them over a valid/ready bus with a timeout watchdog.
- Provides backpressure and a busy flag to the core for store/load ordering.

Parameters:
DEPTH, 2, store-buffer entries (power of two, ≥2)
TIMEOUT, 16, max cycles mem_valid may stay high without mem_ready before the store is dropped

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request from execute stage
st_ready  output  1  controller can accept a store this cycle
st_sel  input  2  store width: 00 byte, 01 half, 10 word, 11 illegal
st_addr  input  32  byte address
st_data  input  32  rs2 value; low bits used for byte/half
flush  input  1  pipeline flush; discards buffered, not-yet-issued stores
mem_valid  output  1  write request to data memory
mem_ready  input  1  memory accepts the write
mem_addr  output  32  word-aligned address
mem_wdata  output  32  lane-replicated write data
mem_wstrb  output  4  byte-lane write enables
misalign_err  output  1  one-cycle pulse: rejected misaligned or illegal store
timeout_err  output  1  one-cycle pulse: issued store dropped by the watchdog
busy  output  1  FIFO non-empty or a write is in flight

Behaviour:
Reset
- Asynchronous on rst_n low: FIFO empty, FSM in IDLE, timer 0.
- All outputs 0 during reset, including st_ready.
- st_ready rises in the first cycle after reset release.

Accept
- st_ready = !full && !flush (combinational from registered full).
- A store is taken when st_valid && st_ready.

Alignment check on accept
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠00; sel=11.
- A misaligned store is consumed but not enqueued; misalign_err pulses the following cycle.

Formatting (registered into the FIFO)
- byte: wdata={4{data[7:0]}}, wstrb=4'b0001<<addr[1:0].
- half: wdata={2{data[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
- word: wdata=data, wstrb=1111.
- mem_addr={addr[31:2],2'b00}.

Latency
- A store accepted at edge N into an empty FIFO drives mem_valid from cycle N+1.

FSM: IDLE, ISSUE
- IDLE→ISSUE when the FIFO is non-empty.
- In ISSUE:
  - mem_valid=1; addr/wdata/wstrb come from the FIFO head and stay stable until the handshake.
  - On mem_valid&&mem_ready: pop the head and clear the timer. Stay in ISSUE if another entry remains (back-to-back, no bubble); otherwise go to IDLE.
  - Without mem_ready: the timer increments each cycle. When the timer reaches TIMEOUT-1 with no ready: pop the head, pulse timeout_err, return to IDLE.
- The timer width is clog2(TIMEOUT+1).

Simultaneous events
- Push and pop in the same cycle are allowed; the occupancy count is unchanged.
- Flush during ISSUE: the head in flight keeps mem_valid until handshake or timeout. All other entries are discarded in the flush cycle; the count becomes 1.
- Flush in IDLE: the FIFO is emptied.
- Flush with st_valid: the store is not accepted (st_ready=0).
- misalign_err and timeout_err may pulse in the same cycle.

Other rules
- busy = (count≠0) || state==ISSUE.
- Full: st_ready=0; the request is held upstream with no loss.
- Empty: mem_valid=0.
- Pointers wrap modulo DEPTH.
- Reset mid-write drops everything; there is no retry after reset.

Decomposition:
- Package store_pkg holds:
  - st_sel encodings ST_SB=2'b00, ST_SH=2'b01, ST_SW=2'b10.
  - FSM state enum {IDLE, ISSUE}.
  - The FIFO entry struct {addr[31:0], wdata[31:0], wstrb[3:0]}.
- One sub-module, store_fifo:
  - parameterised DEPTH, synchronous FIFO of entry structs.
  - Ports: push, pop, flush_keep_head, full, empty, count.
- The lane formatter stays inline in store_issue_ctrl.

Test Plan:
1. Byte store, sel=00, addr=0x1003, data=0xAABBCCDD, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xDDDDDDDD, mem_wstrb=1000; busy falls after 1 cycle.
2. Half store, sel=01, addr=0x2002, data=0x12345678 → mem_wdata=0x56785678, mem_wstrb=1100. Half store at addr=0x2001 → misalign_err pulse, no mem_valid, FIFO count 0.
3. Three word stores back-to-back with mem_ready=0 and DEPTH=2 → st_ready low after 2 accepts. Raise mem_ready → writes issued in order with no bubble; third store accepted once space frees.
4. Word store with mem_ready held 0 and TIMEOUT=16 → mem_valid high exactly 16 cycles, then timeout_err pulse, mem_valid=0, busy=0.
5. Two buffered stores, first in ISSUE; flush asserted with st_valid=1 → st_ready=0, second entry discarded, first completes on mem_ready, busy=0 afterwards.
6. rst_n asserted low mid-ISSUE → mem_valid, st_ready and busy go 0 immediately (asynchronously); after release the FIFO is empty and st_ready=1 the next cycle.
